// File: rtl/cmd_uart.sv
// cmd_uart: sends a 3-byte command through a byte UART and collects a
// 2-byte response (MSB first). Each response byte has its own timeout
// window. A timeout raises a sticky flag and returns the block to idle.
module cmd_uart #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] cmd_data,
   input  logic        snd_cmd,
   output logic        busy,
   output logic [15:0] rsp_data,
   output logic        rsp_rdy,
   input  logic        clr_rsp_rdy,
   output logic        timeout,
   output logic [7:0]  tx_data,
   output logic        trmt,
   input  logic        tx_done,
   input  logic [7:0]  rx_data,
   input  logic        rdy,
   output logic        clr_rdy
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_TX,
      WAIT_MSB,
      ACK_MSB,
      WAIT_LSB,
      ACK_LSB
   } state_t;

   state_t           state;
   state_t           nxt_state;
   logic [1:0]       idx;
   logic [CNT_W-1:0] cnt;
   logic [23:0]      cmd_q;

   logic ld_cmd;
   logic inc_idx;
   logic cnt_clr;
   logic cap_msb;
   logic cap_lsb;
   logic set_rsp;
   logic set_to;
   logic expired;

   assign expired = (cnt == CNT_LAST);
   assign busy    = (state != IDLE);

   // Next-state decode and one-cycle strobes; strobes are masked during reset
   always_comb begin
      nxt_state = state;
      trmt      = 1'b0;
      clr_rdy   = 1'b0;
      ld_cmd    = 1'b0;
      inc_idx   = 1'b0;
      cnt_clr   = 1'b0;
      cap_msb   = 1'b0;
      cap_lsb   = 1'b0;
      set_rsp   = 1'b0;
      set_to    = 1'b0;
      case (state)
         IDLE: begin
            // A byte arriving while idle is unsolicited: acknowledge and drop it
            if (rdy) clr_rdy = 1'b1;
            if (snd_cmd) begin
               ld_cmd    = 1'b1;
               nxt_state = SEND;
            end
         end
         SEND: begin
            trmt      = 1'b1;
            nxt_state = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) begin
               if (idx == 2'd2) begin
                  cnt_clr   = 1'b1;
                  nxt_state = WAIT_MSB;
               end else begin
                  inc_idx   = 1'b1;
                  nxt_state = SEND;
               end
            end
         end
         WAIT_MSB: begin
            // A byte arriving on the last allowed cycle is still accepted
            if (rdy) begin
               cap_msb   = 1'b1;
               nxt_state = ACK_MSB;
            end else if (expired) begin
               set_to    = 1'b1;
               nxt_state = IDLE;
            end
         end
         ACK_MSB: begin
            clr_rdy   = 1'b1;
            cnt_clr   = 1'b1;
            nxt_state = WAIT_LSB;
         end
         WAIT_LSB: begin
            if (rdy) begin
               cap_lsb   = 1'b1;
               nxt_state = ACK_LSB;
            end else if (expired) begin
               set_to    = 1'b1;
               nxt_state = IDLE;
            end
         end
         ACK_LSB: begin
            clr_rdy   = 1'b1;
            set_rsp   = 1'b1;
            nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
      if (rst) begin
         trmt    = 1'b0;
         clr_rdy = 1'b0;
      end
   end

   // State register, byte index and command latch
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= 2'd0;
         cmd_q <= 24'd0;
      end else begin
         state <= nxt_state;
         if (ld_cmd) begin
            cmd_q <= cmd_data;
            idx   <= 2'd0;
         end else if (inc_idx) begin
            idx <= idx + 2'd1;
         end
      end
   end

   // Per-byte response timeout counter, restarted on entry to each wait state
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else if ((state == WAIT_MSB) || (state == WAIT_LSB)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Response assembly plus the ready and sticky timeout flags
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_data <= 16'd0;
         rsp_rdy  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         if (cap_msb) rsp_data[15:8] <= rx_data;
         if (cap_lsb) rsp_data[7:0]  <= rx_data;
         if (set_rsp)
            rsp_rdy <= 1'b1;
         else if (clr_rsp_rdy || ld_cmd)
            rsp_rdy <= 1'b0;
         if (set_to)
            timeout <= 1'b1;
         else if (ld_cmd)
            timeout <= 1'b0;
      end
   end

   // Command byte currently presented to the transmitter
   always_comb begin
      tx_data = 8'h00;
      case (idx)
         2'd0:    tx_data = cmd_q[23:16];
         2'd1:    tx_data = cmd_q[15:8];
         2'd2:    tx_data = cmd_q[7:0];
         default: tx_data = 8'h00;
      endcase
   end

endmodule

// File: doc/cmd_uart.md
CMD_UART -- requirements
Module: cmd_uart

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the max cycles to wait for each response byte.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_data  input  24  command word, byte order [23:16], [15:8], [7:0].
REQ-005 SHALL have port snd_cmd  input  1  one-cycle start strobe.
REQ-006 SHALL have port busy  output  1  high while a transaction is in progress.
REQ-007 SHALL have port rsp_data  output  16  assembled response, MSB byte first on the wire.
REQ-008 SHALL have port rsp_rdy  output  1  high when rsp_data is valid.
REQ-009 SHALL have port clr_rsp_rdy  input  1  clears rsp_rdy.
REQ-010 SHALL have port timeout  output  1  sticky flag set when a response byte is not received in time.
REQ-011 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-012 SHALL have port trmt  output  1  one-cycle transmit strobe to the UART.
REQ-013 SHALL have port tx_done  input  1  UART transmit-complete indication.
REQ-014 SHALL have port rx_data  input  8  UART received byte.
REQ-015 SHALL have port rdy  input  1  UART byte-received flag, held until cleared.
REQ-016 SHALL have port clr_rdy  output  1  one-cycle clear for rdy.

Function
REQ-017 SHALL implement states IDLE, SEND, WAIT_TX, WAIT_MSB, ACK_MSB, WAIT_LSB, ACK_LSB with a 2-bit byte index (0..2).
REQ-018 In IDLE with snd_cmd=1, SHALL latch cmd_data, set index=0, clear timeout, and enter SEND next cycle; snd_cmd SHALL be ignored in all other states.
REQ-019 In SEND, SHALL drive trmt=1 for exactly one cycle, then enter WAIT_TX.
REQ-020 tx_data SHALL equal the latched byte selected by index (0: [23:16], 1: [15:8], 2: [7:0]) and hold stable from SEND until WAIT_TX exits.
REQ-021 In WAIT_TX with tx_done=1: if index<2, SHALL increment index and enter SEND; if index=2, SHALL enter WAIT_MSB; tx_done SHALL be ignored elsewhere.
REQ-022 In WAIT_MSB with rdy=1, SHALL capture rx_data into rsp_data[15:8] and enter ACK_MSB.
REQ-023 In ACK_MSB, SHALL drive clr_rdy=1 for one cycle, ignore rdy, and enter WAIT_LSB.
REQ-024 In WAIT_LSB with rdy=1, SHALL capture rx_data into rsp_data[7:0] and enter ACK_LSB.
REQ-025 In ACK_LSB, SHALL drive clr_rdy=1, set rsp_rdy=1 on the next edge, and return to IDLE.
REQ-026 A timeout counter SHALL clear on entry to WAIT_MSB and WAIT_LSB and count each cycle there.
REQ-027 When the counter reaches TIMEOUT_CYCLES-1 without rdy, SHALL set timeout=1, leave rsp_rdy=0, and return to IDLE.
REQ-028 If rdy and counter expiry coincide, rdy SHALL win.
REQ-029 In IDLE with rdy=1 (stray byte), SHALL pulse clr_rdy for one cycle and discard rx_data; rsp_data SHALL be unchanged.
REQ-030 rsp_rdy SHALL clear on clr_rsp_rdy=1, or on an accepted snd_cmd; clearing SHALL take effect on the same edge.
REQ-031 timeout SHALL stay set until the next accepted snd_cmd.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 trmt and clr_rdy SHALL never be high in the same cycle.

Reset
REQ-034 rst=1 SHALL, on the next edge, force IDLE and set index=0, counter=0, rsp_data=0, rsp_rdy=0, timeout=0, busy=0, trmt=0, clr_rdy=0, tx_data=0.
REQ-035 Reset mid-transaction SHALL abort with no further trmt or clr_rdy pulses.

Verification
REQ-036 snd_cmd with cmd_data=0xA5C33C and tx_done 20 cycles after each trmt -> exactly 3 trmt pulses with tx_data 0xA5, 0xC3, 0x3C; busy high throughout.
REQ-037 After REQ-036, rx bytes 0x12 then 0x34 -> one clr_rdy per byte; rsp_data=0x1234, rsp_rdy=1, busy=0; clr_rsp_rdy clears rsp_rdy.
REQ-038 TIMEOUT_CYCLES=16, no rdy after the third tx_done -> timeout=1 at cycle 16, rsp_rdy=0, IDLE; next snd_cmd clears timeout.
REQ-039 MSB received, LSB withheld past timeout -> timeout=1, rsp_rdy=0; rdy with expiry in the same cycle -> byte accepted, timeout=0.
REQ-040 snd_cmd pulsed during WAIT_TX -> ignored, no extra trmt; rdy in IDLE -> single clr_rdy, rsp_data unchanged.
REQ-041 rst asserted in WAIT_LSB -> all outputs per REQ-034 next cycle; a new snd_cmd then completes normally.
